// File: rtl/apb_master_ctrl_pkg.sv
// Shared definitions for the APB master controller and its neighbours.
//   - FSM state codes (2-bit) and the state enum built from them
//   - default ACCESS stall limit
//   - register map of the timer block sitting on the same APB bus
package apb_master_ctrl_pkg;

  localparam logic [1:0] ST_IDLE_CODE   = 2'd0;
  localparam logic [1:0] ST_SETUP_CODE  = 2'd1;
  localparam logic [1:0] ST_ACCESS_CODE = 2'd2;
  localparam logic [1:0] ST_RESP_CODE   = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE   = ST_IDLE_CODE,
    ST_SETUP  = ST_SETUP_CODE,
    ST_ACCESS = ST_ACCESS_CODE,
    ST_RESP   = ST_RESP_CODE
  } apb_state_t;

  localparam int TIMEOUT_CYCLES_DEFAULT = 16;

  // Timer register map: control, status, data (reload) and live count.
  localparam logic [7:0] TCR_ADDR  = 8'h00;
  localparam logic [7:0] TSR_ADDR  = 8'h01;
  localparam logic [7:0] TDR_ADDR  = 8'h02;
  localparam logic [7:0] TCNT_ADDR = 8'h03;

  // TCR bit positions
  localparam int TCR_EN_BIT   = 0;
  localparam int TCR_IE_BIT   = 1;
  localparam int TCR_AR_BIT   = 7;
  // TSR bit positions
  localparam int TSR_OVF_BIT  = 0;

endpackage

// File: rtl/apb_master_ctrl_if.sv
// Bundle of the command/response handshake and the APB bus seen by the
// APB master controller.
//   cmd_*   : command channel (valid/ready) from the system side
//   rsp_*   : response channel (valid/ready) back to the system side
//   P*      : APB initiator signals toward the slave
// Modports:
//   master : the controller's view (drives cmd_ready, rsp_*, PSEL..PWDATA)
//   slave  : the surrounding logic's view (drives cmd_*, rsp_ready, PRDATA,
//            PREADY, PSLVERR)
interface apb_master_ctrl_if #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 8
);

  logic                  cmd_valid;
  logic                  cmd_ready;
  logic                  cmd_write;
  logic [ADDR_WIDTH-1:0] cmd_addr;
  logic [DATA_WIDTH-1:0] cmd_wdata;

  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [DATA_WIDTH-1:0] rsp_rdata;
  logic                  rsp_err;
  logic                  rsp_timeout;

  logic                  PSEL;
  logic                  PENABLE;
  logic                  PWRITE;
  logic [ADDR_WIDTH-1:0] PADDR;
  logic [DATA_WIDTH-1:0] PWDATA;
  logic [DATA_WIDTH-1:0] PRDATA;
  logic                  PREADY;
  logic                  PSLVERR;

  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_ready,
           PRDATA, PREADY, PSLVERR,
    output cmd_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
           PSEL, PENABLE, PWRITE, PADDR, PWDATA
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_ready,
           PRDATA, PREADY, PSLVERR,
    input  cmd_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
           PSEL, PENABLE, PWRITE, PADDR, PWDATA
  );

endinterface

// File: rtl/apb_wait_timer.sv
// Saturating wait-state counter used to bound the APB ACCESS phase.
//   clk : clock, rising edge
//   rst : synchronous active-high reset (count -> 0)
//   clr : synchronous clear (count -> 0), dominant over en
//   en  : count one stalled cycle at this edge
//   tc  : terminal count - the count reaches MAX at this edge (en high and
//         count == MAX-1); never asserted when MAX == 0
module apb_wait_timer #(
  parameter int MAX = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tc
);

  // MAX == 0 disables the limit; keep a legal 1-bit counter in that case.
  localparam int CW  = (MAX < 1) ? 1 : $clog2(MAX + 1);
  localparam int SAT = (MAX < 1) ? 1 : MAX;
  localparam logic [CW-1:0] SAT_C  = CW'(SAT);
  localparam logic [CW-1:0] LAST_C = CW'(SAT - 1);

  logic [CW-1:0] count;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      count <= '0;
    end else if (en && (count != SAT_C)) begin
      count <= count + CW'(1);
    end
  end

  assign tc = (MAX != 0) && en && (count == LAST_C);

endmodule

// File: rtl/apb_master_ctrl.sv
// APB initiator: turns one command on the cmd channel into a single APB
// read or write (SETUP then ACCESS, waiting on PREADY) and returns the
// result on the rsp channel. A stalled ACCESS is aborted after
// TIMEOUT_CYCLES cycles of PREADY low (0 disables the abort).
// Ports:
//   PCLK   : clock, all logic on the rising edge
//   PRESET : synchronous active-high reset; abandons any transfer
//   bus    : apb_master_ctrl_if.master - cmd/rsp handshake and APB signals
// Every output on bus is a flop.
module apb_master_ctrl
  import apb_master_ctrl_pkg::*;
#(
  parameter int ADDR_WIDTH     = 8,
  parameter int DATA_WIDTH     = 8,
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT
) (
  input  logic              PCLK,
  input  logic              PRESET,
  apb_master_ctrl_if.master bus
);

  apb_state_t state, state_next;

  logic                  wait_clr;
  logic                  wait_en;
  logic                  wait_tc;
  logic [ADDR_WIDTH-1:0] addr_d;
  logic [DATA_WIDTH-1:0] wdata_d;
  logic [DATA_WIDTH-1:0] rdata_d;

  assign addr_d  = bus.cmd_addr;
  assign wdata_d = bus.cmd_wdata;
  // Writes report zero read data.
  assign rdata_d = bus.PWRITE ? '0 : bus.PRDATA;

  // The wait count restarts for every transfer (entry to SETUP) and only
  // advances on stalled ACCESS cycles.
  assign wait_clr = (state == ST_IDLE) && bus.cmd_valid;
  assign wait_en  = (state == ST_ACCESS) && !bus.PREADY;

  apb_wait_timer #(
    .MAX (TIMEOUT_CYCLES)
  ) u_wait_timer (
    .clk (PCLK),
    .rst (PRESET),
    .clr (wait_clr),
    .en  (wait_en),
    .tc  (wait_tc)
  );

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:   if (bus.cmd_valid) state_next = ST_SETUP;
      ST_SETUP:  state_next = ST_ACCESS;
      // PREADY is checked first so a ready slave wins over a same-cycle abort.
      ST_ACCESS: if (bus.PREADY || wait_tc) state_next = ST_RESP;
      ST_RESP:   if (bus.rsp_ready) state_next = ST_IDLE;
      default:   state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      bus.cmd_ready   <= 1'b1;
      bus.PSEL        <= 1'b0;
      bus.PENABLE     <= 1'b0;
      bus.PWRITE      <= 1'b0;
      bus.PADDR       <= '0;
      bus.PWDATA      <= '0;
      bus.rsp_valid   <= 1'b0;
      bus.rsp_rdata   <= '0;
      bus.rsp_err     <= 1'b0;
      bus.rsp_timeout <= 1'b0;
    end else begin
      bus.cmd_ready <= (state_next == ST_IDLE);
      case (state)
        ST_IDLE: begin
          if (bus.cmd_valid) begin
            bus.PADDR   <= addr_d;
            bus.PWRITE  <= bus.cmd_write;
            bus.PSEL    <= 1'b1;
            bus.PENABLE <= 1'b0;
            // Reads leave the last write data on PWDATA.
            if (bus.cmd_write) bus.PWDATA <= wdata_d;
          end
        end
        ST_SETUP: begin
          bus.PENABLE <= 1'b1;
        end
        ST_ACCESS: begin
          if (bus.PREADY) begin
            bus.rsp_err     <= bus.PSLVERR;
            bus.rsp_rdata   <= rdata_d;
            bus.rsp_timeout <= 1'b0;
            bus.rsp_valid   <= 1'b1;
            bus.PSEL        <= 1'b0;
            bus.PENABLE     <= 1'b0;
            bus.PWRITE      <= 1'b0;
          end else if (wait_tc) begin
            bus.rsp_err     <= 1'b1;
            bus.rsp_timeout <= 1'b1;
            bus.rsp_rdata   <= '0;
            bus.rsp_valid   <= 1'b1;
            bus.PSEL        <= 1'b0;
            bus.PENABLE     <= 1'b0;
          end
        end
        ST_RESP: begin
          if (bus.rsp_ready) bus.rsp_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_apb_master_ctrl.sv
// Bench for apb_master_ctrl: a small APB slave with the timer register map
// (TCR/TSR/TDR/TCNT, invalid addresses return PSLVERR and 0xEE read data),
// a table of directed transfers, and hand-written sequences for reset,
// response backpressure and reset in the middle of ACCESS.
module tb_apb_master_ctrl;
  import apb_master_ctrl_pkg::*;

  localparam int TO = 16;
  localparam int DEAD = 255;

  logic clk;
  logic PRESET;

  apb_master_ctrl_if #(.ADDR_WIDTH(8), .DATA_WIDTH(8)) bus ();

  apb_master_ctrl #(
    .ADDR_WIDTH     (8),
    .DATA_WIDTH     (8),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .PCLK   (clk),
    .PRESET (PRESET),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- APB slave model ----------------
  logic [7:0] regs [4];
  int         slv_wait;
  int         acc_cnt;

  assign bus.PREADY  = (slv_wait != DEAD) && (acc_cnt >= slv_wait);
  assign bus.PRDATA  = (bus.PADDR < 8'h04) ? regs[bus.PADDR[1:0]] : 8'hEE;
  assign bus.PSLVERR = bus.PSEL && bus.PENABLE && (bus.PADDR >= 8'h04);

  always @(posedge clk) begin
    if (bus.PSEL && bus.PENABLE && !bus.PREADY) acc_cnt <= acc_cnt + 1;
    else acc_cnt <= 0;
  end

  always @(posedge clk) begin
    if (PRESET) begin
      regs[0] <= 8'h81;
      regs[1] <= 8'h00;
      regs[2] <= 8'h00;
      regs[3] <= 8'h00;
    end else if (bus.PSEL && bus.PENABLE && bus.PREADY && bus.PWRITE &&
                 (bus.PADDR < 8'h04)) begin
      regs[bus.PADDR[1:0]] <= bus.PWDATA;
    end
  end

  // ---------------- checking ----------------
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic       w;
    logic [7:0] addr;
    logic [7:0] wdata;
    int         wait_n;
    logic [7:0] rdata;
    logic       err;
    logic       to;
    int         lat;    // negedges from accept to rsp_valid
  } vec_t;

  vec_t vecs [11];

  // Called at a negedge with cmd_ready expected high; returns at the negedge
  // after the accepting edge.
  task automatic issue(input logic w, input logic [7:0] a, input logic [7:0] d);
    int k;
    k = 0;
    while (!bus.cmd_ready && k < 50) begin
      @(negedge clk);
      k++;
    end
    if (k >= 50) chk("cmd_ready_wait", 32'd0, 32'd1);
    bus.cmd_valid = 1'b1;
    bus.cmd_write = w;
    bus.cmd_addr  = a;
    bus.cmd_wdata = d;
    @(negedge clk);
    bus.cmd_valid = 1'b0;
  endtask

  task automatic run_xfer(input vec_t v, input string tag);
    int         n;
    int         pen;
    logic       stable;
    logic [7:0] a0;
    logic       w0;
    slv_wait = v.wait_n;
    issue(v.w, v.addr, v.wdata);
    n = 1;
    pen = 0;
    stable = 1'b1;
    a0 = bus.PADDR;
    w0 = bus.PWRITE;
    chk({tag, " setup"}, {30'd0, bus.PSEL, bus.PENABLE}, 32'd2);
    chk({tag, " paddr"}, {24'd0, a0}, {24'd0, v.addr});
    while (!bus.rsp_valid && n < 60) begin
      @(negedge clk);
      n++;
      if (bus.PSEL && bus.PENABLE) pen++;
      if (bus.PSEL && ((bus.PADDR !== a0) || (bus.PWRITE !== w0))) stable = 1'b0;
    end
    chk({tag, " latency"}, n, v.lat);
    chk({tag, " access_cycles"}, pen, v.lat - 2);
    chk({tag, " addr_stable"}, {31'd0, stable}, 32'd1);
    chk({tag, " psel_off"}, {31'd0, bus.PSEL}, 32'd0);
    chk({tag, " rdata"}, {24'd0, bus.rsp_rdata}, {24'd0, v.rdata});
    chk({tag, " err"}, {31'd0, bus.rsp_err}, {31'd0, v.err});
    chk({tag, " timeout"}, {31'd0, bus.rsp_timeout}, {31'd0, v.to});
    @(negedge clk);
    chk({tag, " idle"}, {30'd0, bus.rsp_valid, bus.cmd_ready}, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic seen;
    vecs[0]  = '{1'b1, TDR_ADDR,  8'h5A, 0,    8'h00, 1'b0, 1'b0, 3};
    vecs[1]  = '{1'b0, TDR_ADDR,  8'h00, 0,    8'h5A, 1'b0, 1'b0, 3};
    vecs[2]  = '{1'b0, TCR_ADDR,  8'h00, 3,    8'h81, 1'b0, 1'b0, 6};
    vecs[3]  = '{1'b1, 8'h55,     8'hDE, 0,    8'h00, 1'b1, 1'b0, 3};
    vecs[4]  = '{1'b0, 8'h55,     8'h00, 0,    8'hEE, 1'b1, 1'b0, 3};
    vecs[5]  = '{1'b1, TCR_ADDR,  8'h3C, 1,    8'h00, 1'b0, 1'b0, 4};
    vecs[6]  = '{1'b0, TCR_ADDR,  8'h00, 0,    8'h3C, 1'b0, 1'b0, 3};
    vecs[7]  = '{1'b0, TDR_ADDR,  8'h00, DEAD, 8'h00, 1'b1, 1'b1, 18};
    vecs[8]  = '{1'b0, TDR_ADDR,  8'h00, 2,    8'h5A, 1'b0, 1'b0, 5};
    vecs[9]  = '{1'b1, TCNT_ADDR, 8'hA5, 0,    8'h00, 1'b0, 1'b0, 3};
    vecs[10] = '{1'b0, TCNT_ADDR, 8'h00, 0,    8'hA5, 1'b0, 1'b0, 3};

    PRESET = 1'b1;
    slv_wait = 0;
    bus.cmd_valid = 1'b0;
    bus.cmd_write = 1'b0;
    bus.cmd_addr  = 8'h00;
    bus.cmd_wdata = 8'h00;
    bus.rsp_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    PRESET = 1'b0;

    chk("rst psel",      {31'd0, bus.PSEL},        32'd0);
    chk("rst penable",   {31'd0, bus.PENABLE},     32'd0);
    chk("rst pwrite",    {31'd0, bus.PWRITE},      32'd0);
    chk("rst paddr",     {24'd0, bus.PADDR},       32'd0);
    chk("rst pwdata",    {24'd0, bus.PWDATA},      32'd0);
    chk("rst rsp_valid", {31'd0, bus.rsp_valid},   32'd0);
    chk("rst rsp_rdata", {24'd0, bus.rsp_rdata},   32'd0);
    chk("rst rsp_err",   {31'd0, bus.rsp_err},     32'd0);
    chk("rst rsp_to",    {31'd0, bus.rsp_timeout}, 32'd0);
    chk("rst cmd_ready", {31'd0, bus.cmd_ready},   32'd1);

    for (int i = 0; i < 11; i++) begin
      run_xfer(vecs[i], $sformatf("vec%0d", i));
    end
    // Last write was 0xA5; the following read must not disturb PWDATA.
    chk("pwdata_hold", {24'd0, bus.PWDATA}, 32'hA5);

    // Response backpressure: rsp_* held and no new command accepted.
    slv_wait = 0;
    bus.rsp_ready = 1'b0;
    issue(1'b0, TDR_ADDR, 8'h00);
    for (int k = 0; k < 10 && !bus.rsp_valid; k++) @(negedge clk);
    chk("bp first_valid", {31'd0, bus.rsp_valid}, 32'd1);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk($sformatf("bp valid%0d", k), {31'd0, bus.rsp_valid}, 32'd1);
      chk($sformatf("bp rdata%0d", k), {24'd0, bus.rsp_rdata}, 32'h5A);
      chk($sformatf("bp err%0d", k), {30'd0, bus.rsp_err, bus.rsp_timeout}, 32'd0);
      chk($sformatf("bp cmd_ready%0d", k), {31'd0, bus.cmd_ready}, 32'd0);
    end
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    chk("bp release", {30'd0, bus.rsp_valid, bus.cmd_ready}, 32'd1);

    // Reset in the middle of a stalled ACCESS.
    slv_wait = DEAD;
    issue(1'b0, TCR_ADDR, 8'h00);
    @(negedge clk);
    chk("mid access", {30'd0, bus.PSEL, bus.PENABLE}, 32'd3);
    @(negedge clk);
    PRESET = 1'b1;
    @(negedge clk);
    PRESET = 1'b0;
    chk("mrst psel",      {31'd0, bus.PSEL},      32'd0);
    chk("mrst penable",   {31'd0, bus.PENABLE},   32'd0);
    chk("mrst rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
    chk("mrst cmd_ready", {31'd0, bus.cmd_ready}, 32'd1);
    slv_wait = 0;
    seen = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (bus.rsp_valid || bus.PSEL) seen = 1'b1;
    end
    chk("mrst no_rsp", {31'd0, seen}, 32'd0);
    // Slave registers were reset too: TCR back to 0x81.
    run_xfer('{1'b0, TCR_ADDR, 8'h00, 0, 8'h81, 1'b0, 1'b0, 3}, "post_rst");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
